// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the functional-unit writeback request lines and the
// scoreboard-side output stage of the writeback arbiter.
//   slave  : arbiter view. Takes per-port valid/trans_id/data/ex and the
//            scoreboard sb_ready_i; drives wb_ready_o and the sb_* fields.
//   master : environment view (functional units plus scoreboard), opposite
//            directions.
// Signal suffixes are written from the arbiter's point of view.
interface wb_arbiter_if #(
  parameter int unsigned NR_WB_PORTS   = 4,
  parameter int unsigned TRANS_ID_BITS = 2,
  parameter int unsigned DATA_WIDTH    = 64
);
  logic [NR_WB_PORTS-1:0]               wb_valid_i;
  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_i;
  logic [NR_WB_PORTS*DATA_WIDTH-1:0]    wb_data_i;
  logic [NR_WB_PORTS-1:0]               wb_ex_valid_i;
  logic [NR_WB_PORTS*DATA_WIDTH-1:0]    wb_ex_cause_i;
  logic [NR_WB_PORTS-1:0]               wb_ready_o;

  logic                                 sb_valid_o;
  logic [TRANS_ID_BITS-1:0]             sb_trans_id_o;
  logic [DATA_WIDTH-1:0]                sb_data_o;
  logic                                 sb_ex_valid_o;
  logic [DATA_WIDTH-1:0]                sb_ex_cause_o;
  logic                                 sb_ready_i;

  modport slave (
    input  wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_valid_i, wb_ex_cause_i,
    input  sb_ready_i,
    output wb_ready_o,
    output sb_valid_o, sb_trans_id_o, sb_data_o, sb_ex_valid_o, sb_ex_cause_o
  );

  modport master (
    output wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_valid_i, wb_ex_cause_i,
    output sb_ready_i,
    input  wb_ready_o,
    input  sb_valid_o, sb_trans_id_o, sb_data_o, sb_ex_valid_o, sb_ex_cause_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbitration of NR_WB_PORTS functional-unit results
// onto the single scoreboard writeback port, through a one-entry output stage.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, overrides everything
//   flush_i : drops the output stage and blocks acceptance this cycle
//   bus_if  : wb_arbiter_if.slave (per-port requests/ready, sb_* output stage)
module wb_arbiter #(
  parameter int unsigned NR_WB_PORTS   = 4,
  parameter int unsigned TRANS_ID_BITS = 2,
  parameter int unsigned DATA_WIDTH    = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  wb_arbiter_if.slave        bus_if
);
  localparam int unsigned PTR_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     sb_valid_q, sb_valid_d;
  logic [TRANS_ID_BITS-1:0] sb_trans_id_q, sb_trans_id_d;
  logic [DATA_WIDTH-1:0]    sb_data_q, sb_data_d;
  logic                     sb_ex_valid_q, sb_ex_valid_d;
  logic [DATA_WIDTH-1:0]    sb_ex_cause_q, sb_ex_cause_d;

  logic                     load_en;
  logic                     found;
  logic                     accept;
  logic [PTR_W-1:0]         gnt_idx;
  logic [NR_WB_PORTS-1:0]   ready;

  // The output stage may take a new entry when empty or being consumed now.
  assign load_en = !sb_valid_q || bus_if.sb_ready_i;

  // Search from rr_ptr_q upward with wrap; first valid port wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % int'(NR_WB_PORTS);
      if (!found && bus_if.wb_valid_i[idx]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  assign accept = found && load_en && !flush_i && !rst_i;

  always_comb begin
    ready = '0;
    for (int i = 0; i < int'(NR_WB_PORTS); i++) begin
      ready[i] = accept && (int'(gnt_idx) == i);
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    sb_valid_d    = sb_valid_q;
    sb_trans_id_d = sb_trans_id_q;
    sb_data_d     = sb_data_q;
    sb_ex_valid_d = sb_ex_valid_q;
    sb_ex_cause_d = sb_ex_cause_q;
    if (flush_i) begin
      // Data fields are left stale; only the valid bit matters.
      sb_valid_d = 1'b0;
    end else if (accept) begin
      sb_valid_d    = 1'b1;
      sb_trans_id_d = bus_if.wb_trans_id_i[int'(gnt_idx)*TRANS_ID_BITS +: TRANS_ID_BITS];
      sb_data_d     = bus_if.wb_data_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      sb_ex_valid_d = bus_if.wb_ex_valid_i[int'(gnt_idx)];
      sb_ex_cause_d = bus_if.wb_ex_cause_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      rr_ptr_d      = PTR_W'((int'(gnt_idx) + 1) % int'(NR_WB_PORTS));
    end else if (load_en) begin
      sb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q      <= '0;
      sb_valid_q    <= 1'b0;
      sb_trans_id_q <= '0;
      sb_data_q     <= '0;
      sb_ex_valid_q <= 1'b0;
      sb_ex_cause_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      sb_valid_q    <= sb_valid_d;
      sb_trans_id_q <= sb_trans_id_d;
      sb_data_q     <= sb_data_d;
      sb_ex_valid_q <= sb_ex_valid_d;
      sb_ex_cause_q <= sb_ex_cause_d;
    end
  end

  assign bus_if.wb_ready_o    = ready;
  assign bus_if.sb_valid_o    = sb_valid_q;
  assign bus_if.sb_trans_id_o = sb_trans_id_q;
  assign bus_if.sb_data_o     = sb_data_q;
  assign bus_if.sb_ex_valid_o = sb_ex_valid_q;
  assign bus_if.sb_ex_cause_o = sb_ex_cause_q;

`ifndef SYNTHESIS
  logic dup_tid;
  always_comb begin
    dup_tid = 1'b0;
    for (int i = 0; i < int'(NR_WB_PORTS); i++) begin
      for (int j = i + 1; j < int'(NR_WB_PORTS); j++) begin
        if (bus_if.wb_valid_i[i] && bus_if.wb_valid_i[j] &&
            bus_if.wb_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS] ==
            bus_if.wb_trans_id_i[j*TRANS_ID_BITS +: TRANS_ID_BITS]) begin
          dup_tid = 1'b1;
        end
      end
    end
  end

  a_ready_onehot0: assert property (@(posedge clk_i) $onehot0(ready));

  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (sb_valid_q && !bus_if.sb_ready_i && !flush_i) |=>
      ($stable(sb_valid_q) && $stable(sb_trans_id_q) && $stable(sb_data_q) &&
       $stable(sb_ex_valid_q) && $stable(sb_ex_cause_q)));

  a_unique_tid: assert property (@(posedge clk_i) disable iff (rst_i) !dup_tid);
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int NP = 4;
  localparam int TB = 2;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  wb_arbiter_if #(.NR_WB_PORTS(NP), .TRANS_ID_BITS(TB), .DATA_WIDTH(DW)) bus_if ();

  wb_arbiter #(.NR_WB_PORTS(NP), .TRANS_ID_BITS(TB), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus_if  (bus_if)
  );

  logic [63:0] data_c  [NP] = '{64'h1111_0000, 64'h2222_0001, 64'hDEAD_BEEF, 64'h4444_0003};
  logic [63:0] cause_c [NP] = '{64'h10, 64'h5, 64'h12, 64'h13};

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       flush;
    logic [3:0] valid;
    logic [3:0] ex;
    logic       sb_rdy;
    logic [3:0] exp_rdy;
    logic       exp_sv;
    logic [1:0] exp_tid;
    logic       exp_ex;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic f, logic [3:0] v, logic [3:0] e, logic r,
                              logic [3:0] er, logic esv, logic [1:0] et, logic eex);
    vec_t x;
    x.flush = f; x.valid = v; x.ex = e; x.sb_rdy = r;
    x.exp_rdy = er; x.exp_sv = esv; x.exp_tid = et; x.exp_ex = eex;
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic f, logic [3:0] v, logic [3:0] e, logic sr);
    rst   = r;
    flush = f;
    bus_if.wb_valid_i    = v;
    bus_if.wb_ex_valid_i = e;
    bus_if.sb_ready_i    = sr;
  endtask

  // Check the stage contents against the result of port tid (tids equal port numbers).
  task automatic chk_stage(string tag, logic [1:0] tid, logic ex);
    chk({tag, ".sb_trans_id"}, 64'(bus_if.sb_trans_id_o), 64'(tid));
    chk({tag, ".sb_data"}, bus_if.sb_data_o, data_c[tid]);
    chk({tag, ".sb_ex_valid"}, 64'(bus_if.sb_ex_valid_o), 64'(ex));
    if (ex) chk({tag, ".sb_ex_cause"}, bus_if.sb_ex_cause_o, cause_c[tid]);
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      bus_if.wb_trans_id_i[i*TB +: TB] = TB'(i);
      bus_if.wb_data_i[i*DW +: DW]     = data_c[i];
      bus_if.wb_ex_cause_i[i*DW +: DW] = cause_c[i];
    end

    // Reset: ready must stay low even with every port requesting.
    drive(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1);
    @(posedge clk); #1;
    #2 chk("reset.wb_ready", 64'(bus_if.wb_ready_o), 64'h0);
    @(posedge clk); #1;
    chk("reset.sb_valid", 64'(bus_if.sb_valid_o), 64'h0);
    chk("reset.sb_trans_id", 64'(bus_if.sb_trans_id_o), 64'h0);
    chk("reset.sb_data", bus_if.sb_data_o, 64'h0);
    chk("reset.sb_ex_valid", 64'(bus_if.sb_ex_valid_o), 64'h0);
    chk("reset.sb_ex_cause", bus_if.sb_ex_cause_o, 64'h0);

    //              flush valid    ex       rdy  exp_rdy  sv  tid ex
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 1, 0, 0)); // rr 0..3,0
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 1, 2, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 1, 3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 2, 0)); // DEAD_BEEF
    vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 4'b1000, 1, 3, 0)); // ptr=3 beats 0
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0000, 1, 3, 0)); // stall x3
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0000, 1, 3, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0000, 1, 3, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 4'b0001, 1, 0, 0)); // no bubble
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1)); // exception
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0)); // drain
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 2, 0));
    vecs.push_back(mk(1, 4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 0)); // flush
    vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 4'b1000, 1, 3, 0)); // ptr kept at 3

    foreach (vecs[n]) begin
      drive(1'b0, vecs[n].flush, vecs[n].valid, vecs[n].ex, vecs[n].sb_rdy);
      #2 chk($sformatf("v%0d.wb_ready", n), 64'(bus_if.wb_ready_o), 64'(vecs[n].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d.sb_valid", n), 64'(bus_if.sb_valid_o), 64'(vecs[n].exp_sv));
      if (vecs[n].exp_sv) chk_stage($sformatf("v%0d", n), vecs[n].exp_tid, vecs[n].exp_ex);
    end

    // Reset while stalled with a held entry; pointer must return to 0.
    drive(1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1);
    #2 chk("rs.accept1.wb_ready", 64'(bus_if.wb_ready_o), 64'h2);
    @(posedge clk); #1;
    chk("rs.accept1.sb_valid", 64'(bus_if.sb_valid_o), 64'h1);
    drive(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0);
    #2 chk("rs.stall.wb_ready", 64'(bus_if.wb_ready_o), 64'h0);
    @(posedge clk); #1;
    chk_stage("rs.stall", 2'd1, 1'b0);
    drive(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0);
    #2 chk("rs.rst.wb_ready", 64'(bus_if.wb_ready_o), 64'h0);
    @(posedge clk); #1;
    chk("rs.after_rst.sb_valid", 64'(bus_if.sb_valid_o), 64'h0);
    chk("rs.after_rst.sb_data", bus_if.sb_data_o, 64'h0);
    drive(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1);
    #2 chk("rs.first.wb_ready", 64'(bus_if.wb_ready_o), 64'h1);
    @(posedge clk); #1;
    chk("rs.first.sb_valid", 64'(bus_if.sb_valid_o), 64'h1);
    chk_stage("rs.first", 2'd0, 1'b0);

    // Flush while stalled beats the stall; pointer unchanged (next winner 1).
    drive(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0);
    #2 chk("fs.flush.wb_ready", 64'(bus_if.wb_ready_o), 64'h0);
    @(posedge clk); #1;
    chk("fs.flush.sb_valid", 64'(bus_if.sb_valid_o), 64'h0);
    drive(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0);
    #2 chk("fs.empty_accept.wb_ready", 64'(bus_if.wb_ready_o), 64'h2);
    @(posedge clk); #1;
    chk_stage("fs.empty_accept", 2'd1, 1'b0);

    drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
